estacao_reserva_r: RTL and testbench

ESTACAO_RESERVA_R -- requirements
Module: estacao_reserva_r

---
 rtl/estacao_reserva_r_pkg.sv | 30 +++
 rtl/estacao_reserva_r_rs_slot.sv | 89 ++++++++
 rtl/estacao_reserva_r.sv | 161 ++++++++++++++++
 tb/tb_estacao_reserva_r.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/estacao_reserva_r_pkg.sv
// Shared definitions for the reservation station: widths, tag encoding,
// functional-unit op codes, dispatch FSM states and the CDB tag matcher.
package estacao_reserva_r_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 16;
    localparam int OP_W   = 3;

    localparam logic [TAG_W-1:0] TAG_NONE = 4'd0;

    localparam logic [OP_W-1:0] UFOP_NOP = 3'b000;
    localparam logic [OP_W-1:0] UFOP_ADD = 3'b010;
    localparam logic [OP_W-1:0] UFOP_SUB = 3'b011;
    localparam logic [OP_W-1:0] UFOP_SLT = 3'b110;
    localparam logic [OP_W-1:0] UFOP_CMP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } disp_state_t;

    // A broadcast satisfies a pending operand only for a real (nonzero) tag.
    function automatic logic tag_hit(input logic             cdb_valid,
                                     input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] q);
        return cdb_valid && (cdb_tag != TAG_NONE) && (cdb_tag == q);
    endfunction

endpackage

// File: rtl/estacao_reserva_r_rs_slot.sv
// One reservation slot: takes an issued instruction, snoops the CDB for
// its pending operands and is released by the dispatcher.
module rs_slot
    import estacao_reserva_r_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issue_we,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_vj,
    input  logic [DATA_W-1:0] i_vk,
    input  logic [TAG_W-1:0]  i_qj,
    input  logic [TAG_W-1:0]  i_qk,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic              i_free,
    output logic              o_busy,
    output logic              o_ready,
    output logic [OP_W-1:0]   o_op,
    output logic [DATA_W-1:0] o_vj,
    output logic [DATA_W-1:0] o_vk
);
    logic              r_busy;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_vj;
    logic [DATA_W-1:0] r_vk;
    logic [TAG_W-1:0]  r_qj;
    logic [TAG_W-1:0]  r_qk;

    // Bypass hits use the incoming tags, snoop hits use the stored ones.
    logic w_iss_hit_j;
    logic w_iss_hit_k;
    logic w_snp_hit_j;
    logic w_snp_hit_k;

    assign w_iss_hit_j = tag_hit(i_cdb_valid, i_cdb_tag, i_qj);
    assign w_iss_hit_k = tag_hit(i_cdb_valid, i_cdb_tag, i_qk);
    assign w_snp_hit_j = tag_hit(i_cdb_valid, i_cdb_tag, r_qj);
    assign w_snp_hit_k = tag_hit(i_cdb_valid, i_cdb_tag, r_qk);

    // Slot storage: reset, then issue write (with CDB bypass), else free/snoop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_op   <= UFOP_NOP;
            r_vj   <= '0;
            r_vk   <= '0;
            r_qj   <= TAG_NONE;
            r_qk   <= TAG_NONE;
        end else if (i_issue_we) begin
            r_busy <= 1'b1;
            r_op   <= i_op;
            if (w_iss_hit_j) begin
                r_vj <= i_cdb_data;
                r_qj <= TAG_NONE;
            end else begin
                r_vj <= i_vj;
                r_qj <= i_qj;
            end
            if (w_iss_hit_k) begin
                r_vk <= i_cdb_data;
                r_qk <= TAG_NONE;
            end else begin
                r_vk <= i_vk;
                r_qk <= i_qk;
            end
        end else if (r_busy) begin
            if (i_free) begin
                r_busy <= 1'b0;
            end
            if (w_snp_hit_j) begin
                r_vj <= i_cdb_data;
                r_qj <= TAG_NONE;
            end
            if (w_snp_hit_k) begin
                r_vk <= i_cdb_data;
                r_qk <= TAG_NONE;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_ready = r_busy && (r_qj == TAG_NONE) && (r_qk == TAG_NONE);
    assign o_op    = r_op;
    assign o_vj    = r_vj;
    assign o_vk    = r_vk;

endmodule

// File: rtl/estacao_reserva_r.sv
// Reservation station top: slot array, lowest-free issue encoder,
// lowest-ready selector and the IDLE/EXEC/DONE dispatch FSM that drives
// one functional unit.
module estacao_reserva_r
    import estacao_reserva_r_pkg::*;
#(
    parameter int               NUM_ENTRIES = 3,
    parameter logic [TAG_W-1:0] BASE_TAG    = 4'd1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issue_valid,
    input  logic [OP_W-1:0]   i_issue_op,
    input  logic [DATA_W-1:0] i_issue_vj,
    input  logic [DATA_W-1:0] i_issue_vk,
    input  logic [TAG_W-1:0]  i_issue_qj,
    input  logic [TAG_W-1:0]  i_issue_qk,
    output logic              o_full,
    output logic [TAG_W-1:0]  o_issue_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2,
    output logic [OP_W-1:0]   o_ufop,
    output logic              o_ready_to_uf,
    output logic [TAG_W-1:0]  o_uf_tag,
    output logic              o_uf_clear,
    input  logic              i_uf_write_en
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] w_busy;
    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_issue_we;
    logic [NUM_ENTRIES-1:0] w_free;
    logic [OP_W-1:0]        w_op [NUM_ENTRIES];
    logic [DATA_W-1:0]      w_vj [NUM_ENTRIES];
    logic [DATA_W-1:0]      w_vk [NUM_ENTRIES];

    logic                   w_full;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_sel_valid;
    logic [IDX_W-1:0]       w_sel_idx;

    disp_state_t            r_state;
    disp_state_t            w_state_nxt;
    logic                   w_dispatch;
    logic [IDX_W-1:0]       r_exec_idx;
    logic [DATA_W-1:0]      r_op1;
    logic [DATA_W-1:0]      r_op2;
    logic [OP_W-1:0]        r_ufop;
    logic [TAG_W-1:0]       r_uf_tag;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_slot
        assign w_issue_we[g] = i_issue_valid && !w_full && (w_free_idx == IDX_W'(g));

        rs_slot u_slot (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_issue_we  (w_issue_we[g]),
            .i_op        (i_issue_op),
            .i_vj        (i_issue_vj),
            .i_vk        (i_issue_vk),
            .i_qj        (i_issue_qj),
            .i_qk        (i_issue_qk),
            .i_cdb_valid (i_cdb_valid),
            .i_cdb_tag   (i_cdb_tag),
            .i_cdb_data  (i_cdb_data),
            .i_free      (w_free[g]),
            .o_busy      (w_busy[g]),
            .o_ready     (w_ready[g]),
            .o_op        (w_op[g]),
            .o_vj        (w_vj[g]),
            .o_vk        (w_vk[g])
        );
    end

    // Lowest free slot and lowest ready slot, both from registered slot state.
    always_comb begin
        w_full      = 1'b1;
        w_free_idx  = '0;
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!w_busy[i]) begin
                w_full     = 1'b0;
                w_free_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatch next-state: NOPs retire straight from IDLE, real ops go to the UF.
    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        w_free      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    if (w_op[w_sel_idx] == UFOP_NOP) begin
                        w_free[w_sel_idx] = 1'b1;
                    end else begin
                        w_dispatch  = 1'b1;
                        w_state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (i_uf_write_en) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_free[r_exec_idx] = 1'b1;
                w_state_nxt        = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Dispatch state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand/op/tag latch toward the UF; held stable until the next dispatch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exec_idx <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_ufop     <= UFOP_NOP;
            r_uf_tag   <= TAG_NONE;
        end else if (w_dispatch) begin
            r_exec_idx <= w_sel_idx;
            r_op1      <= w_vj[w_sel_idx];
            r_op2      <= w_vk[w_sel_idx];
            r_ufop     <= w_op[w_sel_idx];
            r_uf_tag   <= BASE_TAG + TAG_W'(w_sel_idx);
        end
    end

    assign o_full        = w_full;
    assign o_issue_tag   = w_full ? TAG_NONE : (BASE_TAG + TAG_W'(w_free_idx));
    assign o_op1         = r_op1;
    assign o_op2         = r_op2;
    assign o_ufop        = r_ufop;
    assign o_uf_tag      = r_uf_tag;
    assign o_ready_to_uf = (r_state == ST_EXEC);
    assign o_uf_clear    = (r_state == ST_DONE);

endmodule

// File: tb/tb_estacao_reserva_r.sv
// Self-checking bench for estacao_reserva_r: directed scenarios plus a
// randomized run, all compared against a slot-level reference model.
module tb_estacao_reserva_r;
    import estacao_reserva_r_pkg::*;

    localparam int         N    = 3;
    localparam logic [3:0] BASE = 4'd1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic [2:0]  iss_op = '0;
    logic [15:0] iss_vj = '0, iss_vk = '0;
    logic [3:0]  iss_qj = '0, iss_qk = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [15:0] cdb_data = '0;
    logic        uf_we = 1'b0;

    logic        o_full, o_ready_to_uf, o_uf_clear;
    logic [3:0]  o_issue_tag, o_uf_tag;
    logic [15:0] o_op1, o_op2;
    logic [2:0]  o_ufop;

    estacao_reserva_r dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_issue_valid (iss_valid),
        .i_issue_op    (iss_op),
        .i_issue_vj    (iss_vj),
        .i_issue_vk    (iss_vk),
        .i_issue_qj    (iss_qj),
        .i_issue_qk    (iss_qk),
        .o_full        (o_full),
        .o_issue_tag   (o_issue_tag),
        .i_cdb_valid   (cdb_valid),
        .i_cdb_tag     (cdb_tag),
        .i_cdb_data    (cdb_data),
        .o_op1         (o_op1),
        .o_op2         (o_op2),
        .o_ufop        (o_ufop),
        .o_ready_to_uf (o_ready_to_uf),
        .o_uf_tag      (o_uf_tag),
        .o_uf_clear    (o_uf_clear),
        .i_uf_write_en (uf_we)
    );

    wire [45:0] obs = {o_full, o_issue_tag, o_op1, o_op2, o_ufop,
                       o_ready_to_uf, o_uf_tag, o_uf_clear};
    localparam logic [45:0] RESET_VEC = {1'b0, 4'd1, 16'd0, 16'd0, 3'd0, 1'b0, 4'd0, 1'b0};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: slot contents plus "which phase is the unit in".
    logic        m_busy [N];
    logic [2:0]  m_op   [N];
    logic [15:0] m_vj   [N];
    logic [15:0] m_vk   [N];
    logic [3:0]  m_qj   [N];
    logic [3:0]  m_qk   [N];
    int          m_phase;   // 0 waiting for work, 1 unit executing, 2 completion cycle
    int          m_exec;
    logic [15:0] m_op1, m_op2;
    logic [2:0]  m_ufop;
    logic [3:0]  m_uf_tag;

    function automatic logic [45:0] exp_vec();
        logic       full = 1'b1;
        logic [3:0] it   = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!m_busy[i]) begin
                full = 1'b0;
                it   = BASE + 4'(i);
            end
        end
        return {full, it, m_op1, m_op2, m_ufop, (m_phase == 1), m_uf_tag, (m_phase == 2)};
    endfunction

    function automatic logic hit(input logic [3:0] q);
        return cdb_valid && (cdb_tag != 4'd0) && (cdb_tag == q);
    endfunction

    task automatic model_edge();
        int fi, sel;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 1'b0; m_op[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
                m_qj[i] = '0; m_qk[i] = '0;
            end
            m_phase = 0; m_exec = 0;
            m_op1 = '0; m_op2 = '0; m_ufop = '0; m_uf_tag = '0;
            return;
        end
        fi = -1; sel = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (!m_busy[i]) fi = i;
            if (m_busy[i] && m_qj[i] == 4'd0 && m_qk[i] == 4'd0) sel = i;
        end
        if (m_phase == 0) begin
            if (sel >= 0) begin
                if (m_op[sel] == UFOP_NOP) begin
                    m_busy[sel] = 1'b0;
                end else begin
                    m_op1 = m_vj[sel]; m_op2 = m_vk[sel]; m_ufop = m_op[sel];
                    m_uf_tag = BASE + 4'(sel); m_exec = sel; m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (uf_we) m_phase = 2;
        end else begin
            m_busy[m_exec] = 1'b0;
            m_phase = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                if (hit(m_qj[i])) begin m_vj[i] = cdb_data; m_qj[i] = 4'd0; end
                if (hit(m_qk[i])) begin m_vk[i] = cdb_data; m_qk[i] = 4'd0; end
            end
        end
        if (iss_valid && fi >= 0) begin
            m_busy[fi] = 1'b1; m_op[fi] = iss_op;
            if (hit(iss_qj)) begin m_vj[fi] = cdb_data; m_qj[fi] = 4'd0; end
            else begin m_vj[fi] = iss_vj; m_qj[fi] = iss_qj; end
            if (hit(iss_qk)) begin m_vk[fi] = cdb_data; m_qk[fi] = 4'd0; end
            else begin m_vk[fi] = iss_vk; m_qk[fi] = iss_qk; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_op = '0; iss_vj = '0; iss_vk = '0; iss_qj = '0; iss_qk = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; uf_we = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk);
        iss_valid = 1'b1; iss_op = op; iss_vj = vj; iss_vk = vk; iss_qj = qj; iss_qk = qk;
    endtask

    // Acknowledge whatever reaches the unit until the station has emptied.
    task automatic drain();
        idle_inputs();
        for (int c = 0; c < 30; c++) begin
            uf_we = o_ready_to_uf;
            tick();
        end
        uf_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs();
        tick(); tick();
        rst = 1'b0;
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", obs, RESET_VEC);
        end
        tick();
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_add();
        issue(UFOP_ADD, 16'd5, 16'd7, 4'd0, 4'd0);
        tick(); idle_inputs();
        n_tests++;
        if ({o_ready_to_uf, o_issue_tag} !== {1'b0, 4'd2}) begin
            n_fail++; $display("FAIL add_issued: got rdy/tag %b/%0d expected 0/2", o_ready_to_uf, o_issue_tag);
        end
        tick();
        n_tests++;
        if ({o_ready_to_uf, o_op1, o_op2, o_ufop, o_uf_tag} !== {1'b1, 16'd5, 16'd7, 3'b010, 4'd1}) begin
            n_fail++; $display("FAIL add_dispatch: got rdy=%b op1=%0d op2=%0d ufop=%b tag=%0d expected 1/5/7/010/1",
                               o_ready_to_uf, o_op1, o_op2, o_ufop, o_uf_tag);
        end
        tick();
        n_tests++;
        if ({o_ready_to_uf, o_op1, o_uf_tag} !== {1'b1, 16'd5, 4'd1}) begin
            n_fail++; $display("FAIL add_hold: got rdy=%b op1=%0d tag=%0d expected 1/5/1", o_ready_to_uf, o_op1, o_uf_tag);
        end
        uf_we = 1'b1; tick(); uf_we = 1'b0;
        n_tests++;
        if ({o_uf_clear, o_ready_to_uf, o_issue_tag} !== {1'b1, 1'b0, 4'd2}) begin
            n_fail++; $display("FAIL add_done: got clr/rdy/tag %b/%b/%0d expected 1/0/2", o_uf_clear, o_ready_to_uf, o_issue_tag);
        end
        tick();
        n_tests++;
        if ({o_uf_clear, o_full, o_issue_tag} !== {1'b0, 1'b0, 4'd1}) begin
            n_fail++; $display("FAIL add_freed: got clr/full/tag %b/%b/%0d expected 0/0/1", o_uf_clear, o_full, o_issue_tag);
        end
    endtask

    task automatic test_cdb_wait();
        bit seen = 0;
        issue(UFOP_SUB, 16'd0, 16'd3, 4'd9, 4'd0);
        tick(); idle_inputs();
        tick();
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 16'd20;
        tick(); idle_inputs();
        n_tests++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL wait_captured: got %h expected %h", obs, exp_vec());
        end
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            seen = o_ready_to_uf;
        end
        n_tests++;
        if (!seen || {o_op1, o_op2, o_ufop} !== {16'd20, 16'd3, 3'b011}) begin
            n_fail++; $display("FAIL wait_dispatch: got rdy=%b op1=%0d op2=%0d ufop=%b expected 1/20/3/011",
                               seen, o_op1, o_op2, o_ufop);
        end
        drain();
    endtask

    task automatic test_bypass();
        issue(UFOP_ADD, 16'd1, 16'hDEAD, 4'd0, 4'd9);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 16'h00FF;
        tick(); idle_inputs();
        tick();
        n_tests++;
        if ({o_ready_to_uf, o_op1, o_op2} !== {1'b1, 16'd1, 16'h00FF}) begin
            n_fail++; $display("FAIL bypass: got rdy=%b op1=%h op2=%h expected 1/0001/00ff", o_ready_to_uf, o_op1, o_op2);
        end
        drain();
    endtask

    task automatic test_full();
        issue(UFOP_ADD, 16'h11, 16'h0, 4'd9, 4'd0); tick();
        issue(UFOP_ADD, 16'd2, 16'd3, 4'd0, 4'd0);  tick();
        issue(UFOP_SUB, 16'd8, 16'd4, 4'd0, 4'd0);  tick();
        idle_inputs();
        n_tests++;
        if ({o_full, o_issue_tag} !== {1'b1, 4'd0}) begin
            n_fail++; $display("FAIL full_set: got full/tag %b/%0d expected 1/0", o_full, o_issue_tag);
        end
        issue(UFOP_CMP, 16'd9, 16'd9, 4'd0, 4'd0); tick(); idle_inputs();
        n_tests++;
        if (obs !== exp_vec() || o_uf_tag !== 4'd2) begin
            n_fail++; $display("FAIL full_ignore: got %h expected %h", obs, exp_vec());
        end
        uf_we = 1'b1; tick(); uf_we = 1'b0;
        n_tests++;
        if ({o_uf_clear, o_full} !== 2'b11) begin
            n_fail++; $display("FAIL full_during_done: got clr/full %b/%b expected 1/1", o_uf_clear, o_full);
        end
        tick();
        n_tests++;
        if ({o_full, o_issue_tag} !== {1'b0, 4'd2}) begin
            n_fail++; $display("FAIL full_drop: got full/tag %b/%0d expected 0/2", o_full, o_issue_tag);
        end
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 16'h0042; tick();
        drain();
        n_tests++;
        if (obs !== exp_vec() || {o_full, o_issue_tag} !== {1'b0, 4'd1}) begin
            n_fail++; $display("FAIL full_drained: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_order();
        issue(UFOP_ADD, 16'd10, 16'd20, 4'd0, 4'd0); tick();
        issue(UFOP_SUB, 16'd30, 16'd5, 4'd0, 4'd0);  tick();
        idle_inputs();
        n_tests++;
        if ({o_ready_to_uf, o_uf_tag, o_op1} !== {1'b1, 4'd1, 16'd10}) begin
            n_fail++; $display("FAIL order_first: got rdy/tag/op1 %b/%0d/%0d expected 1/1/10", o_ready_to_uf, o_uf_tag, o_op1);
        end
        uf_we = 1'b1; tick(); uf_we = 1'b0;
        tick(); tick();
        n_tests++;
        if ({o_ready_to_uf, o_uf_tag, o_op1, o_op2, o_ufop} !== {1'b1, 4'd2, 16'd30, 16'd5, 3'b011}) begin
            n_fail++; $display("FAIL order_second: got rdy/tag/op1/op2/ufop %b/%0d/%0d/%0d/%b expected 1/2/30/5/011",
                               o_ready_to_uf, o_uf_tag, o_op1, o_op2, o_ufop);
        end
        drain();
        issue(UFOP_NOP, 16'd1, 16'd1, 4'd0, 4'd0); tick(); idle_inputs();
        n_tests++;
        if ({o_ready_to_uf, o_issue_tag} !== {1'b0, 4'd2}) begin
            n_fail++; $display("FAIL nop_held: got rdy/tag %b/%0d expected 0/2", o_ready_to_uf, o_issue_tag);
        end
        tick();
        n_tests++;
        if ({o_ready_to_uf, o_uf_clear, o_issue_tag} !== {1'b0, 1'b0, 4'd1}) begin
            n_fail++; $display("FAIL nop_freed: got rdy/clr/tag %b/%b/%0d expected 0/0/1", o_ready_to_uf, o_uf_clear, o_issue_tag);
        end
    endtask

    task automatic test_reset_mid_exec();
        issue(UFOP_ADD, 16'h1234, 16'h5678, 4'd0, 4'd0); tick();
        issue(UFOP_SLT, 16'd1, 16'd2, 4'd7, 4'd0);       tick();
        idle_inputs();
        n_tests++;
        if ({o_ready_to_uf, o_op1} !== {1'b1, 16'h1234}) begin
            n_fail++; $display("FAIL rstexec_pre: got rdy/op1 %b/%h expected 1/1234", o_ready_to_uf, o_op1);
        end
        rst = 1'b1; uf_we = 1'b1;
        issue(UFOP_ADD, 16'd3, 16'd3, 4'd0, 4'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 16'hBEEF;
        tick();
        rst = 1'b0; idle_inputs();
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL rstexec_post: got %h expected %h", obs, RESET_VEC);
        end
        tick();
        n_tests++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("FAIL rstexec_quiet: got %h expected %h", obs, RESET_VEC);
        end
    endtask

    task automatic test_random();
        logic [2:0] ops [5] = '{UFOP_NOP, UFOP_ADD, UFOP_SUB, UFOP_SLT, UFOP_CMP};
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_op    = ops[$urandom_range(0, 4)];
            iss_vj    = 16'($urandom);
            iss_vk    = 16'($urandom);
            iss_qj    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(8, 11));
            iss_qk    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(8, 11));
            cdb_valid = ($urandom_range(0, 1) == 0);
            cdb_tag   = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(8, 11));
            cdb_data  = 16'($urandom);
            uf_we     = ($urandom_range(0, 2) == 0);
            tick();
            n_tests++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle_%0d: got %h expected %h", c, obs, exp_vec());
            end
        end
        rst = 1'b0; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_add();
        test_cdb_wait();
        test_bypass();
        test_full();
        test_order();
        test_reset_mid_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
